// File: rtl/mem_scan_reader_if.sv
// Read-port bundle between mem_scan_reader (master) and the synchronous data RAM (slave).
interface mem_scan_reader_if #(
    parameter int unsigned ADDR_W = 6
) ();
    logic [ADDR_W-1:0] Mem_Addr;
    logic              Mem_Read;
    logic [31:0]       Mem_Data;

    modport master (output Mem_Addr, output Mem_Read, input Mem_Data);
    modport slave  (input Mem_Addr, input Mem_Read, output Mem_Data);
endinterface

// File: rtl/mem_scan_reader.sv
// Scans a word-address range of the data RAM and shows each word on the LEDs byte by byte.
// Define SCAN_LOOP_EN to make the scan restart from Start_Addr forever instead of stopping.
module mem_scan_reader #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DWELL  = 50000000,
    parameter int unsigned CNT_W  = 26
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Start,
    input  logic [ADDR_W-1:0]       Start_Addr,
    input  logic [ADDR_W-1:0]       End_Addr,
    mem_scan_reader_if.master       mem,
    output logic [1:0]              Choose,
    output logic [7:0]              LED,
    output logic                    Busy,
    output logic                    Done
);

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StShow, StNext} state_e;

    state_e            state;
    logic [31:0]       word;
    logic [CNT_W-1:0]  dwell_cnt;
    logic [ADDR_W-1:0] last_addr;
`ifdef SCAN_LOOP_EN
    logic [ADDR_W-1:0] first_addr;
`endif

    logic       dwell_end;
    logic [1:0] choose_inc;

    assign dwell_end  = (dwell_cnt == CNT_W'(DWELL - 1));
    assign choose_inc = Choose + 2'd1;

    // Mem_Addr doubles as the current-address register, so it holds its last value when idle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= StIdle;
            word         <= '0;
            dwell_cnt    <= '0;
            last_addr    <= '0;
`ifdef SCAN_LOOP_EN
            first_addr   <= '0;
`endif
            mem.Mem_Addr <= '0;
            mem.Mem_Read <= 1'b0;
            Choose       <= 2'd0;
            LED          <= 8'd0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else begin
            mem.Mem_Read <= 1'b0;
            Done         <= 1'b0;
            case (state)
                StIdle: begin
                    if (Start) begin
                        last_addr    <= End_Addr;
`ifdef SCAN_LOOP_EN
                        first_addr   <= Start_Addr;
`endif
                        mem.Mem_Addr <= Start_Addr;
                        mem.Mem_Read <= 1'b1;
                        Busy         <= 1'b1;
                        state        <= StFetch;
                    end
                end
                StFetch: state <= StWait;
                StWait: begin
                    // Load byte 0 straight from the RAM so LED is valid on the first SHOW cycle.
                    word      <= mem.Mem_Data;
                    LED       <= mem.Mem_Data[7:0];
                    Choose    <= 2'd0;
                    dwell_cnt <= '0;
                    state     <= StShow;
                end
                StShow: begin
                    if (dwell_end) begin
                        dwell_cnt <= '0;
                        if (Choose == 2'd3) begin
                            state <= StNext;
                        end else begin
                            Choose <= choose_inc;
                            LED    <= word[{choose_inc, 3'b000} +: 8];
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                StNext: begin
                    if (mem.Mem_Addr == last_addr) begin
                        Done <= 1'b1;
`ifdef SCAN_LOOP_EN
                        mem.Mem_Addr <= first_addr;
                        mem.Mem_Read <= 1'b1;
                        state        <= StFetch;
`else
                        Busy  <= 1'b0;
                        state <= StIdle;
`endif
                    end else begin
                        mem.Mem_Addr <= mem.Mem_Addr + 1'b1;
                        mem.Mem_Read <= 1'b1;
                        state        <= StFetch;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_scan_reader.sv
// Scoreboard bench for mem_scan_reader: expected fetch addresses and LED bytes are queued
// when a scan is started and consumed as the DUT fetches and displays.
module tb_mem_scan_reader;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DWELL  = 4;
    localparam int unsigned CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W-1:0] end_addr = '0;
    logic [1:0]        choose;
    logic [7:0]        led;
    logic              busy;
    logic              done;

    mem_scan_reader_if #(.ADDR_W(ADDR_W)) bus ();

    mem_scan_reader #(
        .ADDR_W (ADDR_W),
        .DWELL  (DWELL),
        .CNT_W  (CNT_W)
    ) dut (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .Start      (start),
        .Start_Addr (start_addr),
        .End_Addr   (end_addr),
        .mem        (bus),
        .Choose     (choose),
        .LED        (led),
        .Busy       (busy),
        .Done       (done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_arr [64];

    // Sync RAM; read data is garbage unless a read was issued the previous cycle.
    initial begin
        bus.Mem_Data = '0;
        forever begin
            @(posedge clk);
            if (bus.Mem_Read) bus.Mem_Data <= mem_arr[bus.Mem_Addr];
            else              bus.Mem_Data <= $urandom;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    logic [ADDR_W-1:0] exp_addr [$];
    logic [7:0]        exp_led  [$];

    int   cyc         = 0;
    int   rd_at       = -1;
    int   rd_count    = 0;
    int   done_count  = 0;
    int   busy_cycles = 0;
    logic prev_rd     = 1'b0;
    logic [7:0] cur_byte = '0;

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                rd_at   = -1;
                prev_rd = 1'b0;
            end else begin
                if (bus.Mem_Read) begin
                    check("rd_pulse", {31'd0, prev_rd}, 32'd0);
                    if (exp_addr.size() == 0) begin
                        check("extra_fetch", {26'd0, bus.Mem_Addr}, 32'hffff_ffff);
                    end else begin
                        check("fetch_addr", {26'd0, bus.Mem_Addr}, {26'd0, exp_addr.pop_front()});
                    end
                    rd_at = cyc;
                    rd_count++;
                end
                prev_rd = bus.Mem_Read;
                if (rd_at >= 0) begin
                    int d;
                    d = cyc - rd_at - 2;
                    if (d >= 0 && d < 16) begin
                        if (d % 4 == 0) begin
                            if (exp_led.size() == 0) begin
                                check("led_underflow", {24'd0, led}, 32'hffff_ffff);
                            end else begin
                                cur_byte = exp_led.pop_front();
                            end
                        end
                        if (d % 4 == 0 || d % 4 == 3) begin
                            check("led", {24'd0, led}, {24'd0, cur_byte});
                            check("choose", {30'd0, choose}, d / 4);
                        end
                    end
                end
                if (done) done_count++;
                if (busy) busy_cycles++;
            end
        end
    end

    task automatic push_scan(input int s, input int e);
        int a;
        a = s;
        forever begin
            exp_addr.push_back(ADDR_W'(a));
            for (int k = 0; k < 4; k++) exp_led.push_back(mem_arr[a][8*k +: 8]);
            if (a == e) break;
            a = (a + 1) % 64;
        end
    endtask

    task automatic pulse_start(input int s, input int e);
        @(negedge clk);
        start      = 1'b1;
        start_addr = ADDR_W'(s);
        end_addr   = ADDR_W'(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic begin_scan(input int s, input int e);
        done_count  = 0;
        rd_count    = 0;
        busy_cycles = 0;
        push_scan(s, e);
        pulse_start(s, e);
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_count >= n) break;
        end
        check("done_timeout", {31'd0, done_count >= n}, 32'd1);
    endtask

    task automatic finish_scan(input string tag, input int words);
        wait_done(1, 200);
        repeat (5) @(negedge clk);
        check({tag, "_done"}, done_count, 1);
        check({tag, "_reads"}, rd_count, words);
        check({tag, "_busy_cyc"}, busy_cycles, words * 19);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_addr_q"}, exp_addr.size(), 0);
        check({tag, "_led_q"}, exp_led.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_arr[i] = $urandom;
        mem_arr[17] = 32'h1234_5678;

        #13;
        check("rst_led", {24'd0, led}, 32'd0);
        check("rst_choose", {30'd0, choose}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rd", {31'd0, bus.Mem_Read}, 32'd0);
        check("rst_addr", {26'd0, bus.Mem_Addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort mid-SHOW with an asynchronous reset.
        begin_scan(17, 17);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_led", {24'd0, led}, 32'd0);
        check("abort_choose", {30'd0, choose}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_addr", {26'd0, bus.Mem_Addr}, 32'd0);
        check("abort_rd", {31'd0, bus.Mem_Read}, 32'd0);
        exp_addr.delete();
        exp_led.delete();
        rd_at = -1;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SCAN_LOOP_EN
        mem_arr[16] = 32'hA1B2_C3D4;
        begin_scan(16, 16);
        push_scan(16, 16);
        push_scan(16, 16);
        wait_done(2, 200);
        #1;
        check("loop_busy", {31'd0, busy}, 32'd1);
        check("loop_refetch", exp_addr.size(), 0);
        check("loop_reads", rd_count, 3);
        rst_n = 1'b0;
        exp_addr.delete();
        exp_led.delete();
        @(negedge clk);
        rst_n = 1'b1;
`else
        begin_scan(17, 17);
        finish_scan("single", 1);
        check("single_hold_led", {24'd0, led}, 32'h12);
        check("single_hold_choose", {30'd0, choose}, 32'd3);
        check("single_hold_addr", {26'd0, bus.Mem_Addr}, 32'd17);

        mem_arr[16] = 32'hAABB_CCDD;
        mem_arr[17] = 32'h1122_3344;
        begin_scan(16, 17);
        finish_scan("multi", 2);

        mem_arr[63] = 32'h0000_00FF;
        mem_arr[0]  = 32'h0000_0001;
        begin_scan(63, 0);
        finish_scan("wrap", 2);

        // Start while busy must be ignored.
        begin_scan(16, 17);
        repeat (6) @(negedge clk);
        pulse_start(5, 5);
        finish_scan("ignore", 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
